// File: rtl/gate_chk_pkg.sv
// Shared definitions for the gate truth-table sweep checker:
// reference-function op codes and the sweep FSM state encoding.
package gate_chk_pkg;

  localparam logic [2:0] OP_NOR  = 3'd0;
  localparam logic [2:0] OP_NAND = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_BUF  = 3'd6;
  localparam logic [2:0] OP_NOT  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/gate_ref_model.sv
// Combinational reference function for an N_IN-input gate. Multi-input
// functions reduce over every bit of the vector; BUF/NOT look at bit 0 only.
module gate_ref_model
  import gate_chk_pkg::*;
#(
  parameter int N_IN = 2
) (
  input  logic [2:0]      op_sel,
  input  logic [N_IN-1:0] vec_out,
  output logic            exp_f
);

  // Select the expected gate output for the current vector.
  always_comb begin
    exp_f = 1'b0;
    case (op_sel)
      OP_NOR:  exp_f = ~(|vec_out);
      OP_NAND: exp_f = ~(&vec_out);
      OP_AND:  exp_f = &vec_out;
      OP_OR:   exp_f = |vec_out;
      OP_XOR:  exp_f = ^vec_out;
      OP_XNOR: exp_f = ~(^vec_out);
      OP_BUF:  exp_f = vec_out[0];
      OP_NOT:  exp_f = ~vec_out[0];
      default: exp_f = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_sweep_checker.sv
// Exhaustive truth-table exerciser: steps vec_out through every input
// vector, holds each for DWELL cycles, then spends one cycle comparing the
// gate output against the latched reference function. Records the number of
// mismatches and the first failing vector.
module gate_sweep_checker
  import gate_chk_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter int DWELL = 10,
  parameter int CNT_W = N_IN + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op_sel,
  output logic [N_IN-1:0]  vec_out,
  input  logic             dut_f,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic             fail_vld,
  output logic [N_IN-1:0]  fail_vec
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);

  state_e            state_q, state_d;
  logic [DW_W-1:0]   dwell_q, dwell_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [2:0]        op_q, op_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic              fvld_q, fvld_d;
  logic [N_IN-1:0]   fvec_q, fvec_d;
  logic              exp_f_s;

  gate_ref_model #(.N_IN(N_IN)) u_ref (
    .op_sel  (op_q),
    .vec_out (vec_q),
    .exp_f   (exp_f_s)
  );

  // Next-state and result-register logic for the sweep sequencer.
  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    vec_d   = vec_q;
    op_d    = op_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fvld_d  = fvld_q;
    fvec_d  = fvec_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          // Fresh sweep: nothing from a previous run survives.
          state_d = ST_APPLY;
          op_d    = op_sel;
          vec_d   = '0;
          dwell_d = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = '0;
          fvld_d  = 1'b0;
          fvec_d  = '0;
        end else begin
          state_d = state_q;
        end
      end
      ST_APPLY: begin
        dwell_d = dwell_q + 1'b1;
        if (dwell_q == DWELL_LAST) begin
          state_d = ST_SAMPLE;
        end else begin
          state_d = ST_APPLY;
        end
      end
      ST_SAMPLE: begin
        if (dut_f != exp_f_s) begin
          // Saturate rather than wrap so a count never reads as clean.
          if (err_q != '1) begin
            err_d = err_q + 1'b1;
          end else begin
            err_d = err_q;
          end
          if (!fvld_q) begin
            fvld_d = 1'b1;
            fvec_d = vec_q;
          end else begin
            fvld_d = fvld_q;
          end
        end else begin
          err_d = err_q;
        end
        if (&vec_q) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          state_d = ST_APPLY;
          vec_d   = vec_q + 1'b1;
          dwell_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers; reset drops any partial result immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dwell_q <= '0;
      vec_q   <= '0;
      op_q    <= OP_NOR;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fvld_q  <= 1'b0;
      fvec_q  <= '0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      vec_q   <= vec_d;
      op_q    <= op_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fvld_q  <= fvld_d;
      fvec_q  <= fvec_d;
    end
  end

  assign vec_out  = vec_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_cnt  = err_q;
  assign fail_vld = fvld_q;
  assign fail_vec = fvec_q;

endmodule
